ula_arbiter: RTL

Two-requester arbiter and sequencer in front of the processor's single ULA instance. It accepts operation requests from two masters (port 0 and port 1), grants the ULA round-robin, and latches operands and opcode. It returns a registered 8-bit result with a one-cycle done pulse tagged with the winning requester's ID. The ULA itself is instantiated inside this block and is combinational; all sequencing, operand holding and error flagging live here.

---
 rtl/ula_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
// Two-master round-robin front end for the shared combinational ULA.
// Grants in IDLE, evaluates latched operands in EXEC, then returns to IDLE via DONE.
module ula_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] opcode0,
  input  logic [3:0] opcode1,
  input  logic [3:0] op1_0,
  input  logic [3:0] op1_1,
  input  logic [2:0] op2_0,
  input  logic [2:0] op2_1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       done,
  output logic       resp_id,
  output logic [7:0] result,
  output logic       err,
  output logic [7:0] op_count
);

  localparam logic [3:0] ULA_ADD  = 4'd0;
  localparam logic [3:0] ULA_SUB  = 4'd1;
  localparam logic [3:0] ULA_MULT = 4'd2;
  localparam logic [3:0] ULA_DIV  = 4'd3;
  localparam logic [3:0] ULA_AND  = 4'd4;
  localparam logic [3:0] ULA_OR   = 4'd5;
  localparam logic [3:0] ULA_XOR  = 4'd6;
  localparam logic [3:0] ULA_NOT  = 4'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  opc_q, opc_d;
  logic [3:0]  opa_q, opa_d;
  logic [2:0]  opb_q, opb_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        done_q, done_d;
  logic        resp_id_q, resp_id_d;
  logic [7:0]  result_q, result_d;
  logic        err_q, err_d;
  logic [7:0]  op_count_q, op_count_d;

  logic [3:0]  opb_ext;
  logic [3:0]  ula_sum;
  logic [7:0]  ula_y;
  logic        ula_err;
  logic        grant1;

  // The ULA only ever sees the latched operands, never the live ports.
  always_comb begin
    opb_ext = {1'b0, opb_q};
    ula_sum = opa_q + opb_ext;
    ula_y   = 8'h00;
    case (opc_q)
      ULA_ADD:  ula_y = {4'h0, ula_sum};
      ULA_SUB:  ula_y = (opa_q >= opb_ext) ? {4'h0, opa_q - opb_ext} : {4'h0, opb_ext - opa_q};
      ULA_MULT: ula_y = {4'h0, opa_q} * {4'h0, opb_ext};
      ULA_DIV:  ula_y = (opb_q == 3'd0) ? 8'h00 : {4'h0, opa_q / opb_ext};
      ULA_AND:  ula_y = {4'h0, opa_q & opb_ext};
      ULA_OR:   ula_y = {4'h0, opa_q | opb_ext};
      ULA_XOR:  ula_y = {4'h0, opa_q ^ opb_ext};
      ULA_NOT:  ula_y = {4'h0, ~opa_q};
      default:  ula_y = 8'h00;
    endcase
    ula_err = ((opc_q == ULA_DIV) && (opb_q == 3'd0)) || opc_q[3];
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    opc_d      = opc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done_d     = 1'b0;
    resp_id_d  = resp_id_q;
    result_d   = result_q;
    err_d      = err_q;
    op_count_d = op_count_q;
    grant1     = req1 && (!req0 || !last_q);
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          opc_d     = grant1 ? opcode1 : opcode0;
          opa_d     = grant1 ? op1_1   : op1_0;
          opb_d     = grant1 ? op2_1   : op2_0;
          ack0_d    = !grant1;
          ack1_d    = grant1;
          resp_id_d = grant1;
          last_d    = grant1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d   = ula_err ? 8'h00 : ula_y;
        err_d      = ula_err;
        done_d     = 1'b1;
        op_count_d = op_count_q + 8'd1;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      opc_q      <= 4'h0;
      opa_q      <= 4'h0;
      opb_q      <= 3'h0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_id_q  <= 1'b0;
      result_q   <= 8'h00;
      err_q      <= 1'b0;
      op_count_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      opc_q      <= opc_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done_q     <= done_d;
      resp_id_q  <= resp_id_d;
      result_q   <= result_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = (state_q == EXEC) || (state_q == DONE);
  assign done     = done_q;
  assign resp_id  = resp_id_q;
  assign result   = result_q;
  assign err      = err_q;
  assign op_count = op_count_q;

endmodule
